// File: rtl/operand_fetch_if.sv
// Handshake and data bundle between decode, register file, writeback and the
// operand_fetch stage; the slave modport is the stage's view.
interface operand_fetch_if #(
  parameter int unsigned RF_ADDR_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [RF_ADDR_W-1:0] in_rs1;
  logic [RF_ADDR_W-1:0] in_rs2;
  logic [RF_ADDR_W-1:0] in_rd;
  logic                 in_uses_rs1;
  logic                 in_uses_rs2;
  logic                 in_rd_we;
  logic [31:0]          in_pc;
  logic [31:0]          in_ctrl;

  logic [RF_ADDR_W-1:0] rf_rs1;
  logic [RF_ADDR_W-1:0] rf_rs2;
  logic [31:0]          rf_rs1_data;
  logic [31:0]          rf_rs2_data;

  logic                 wb_valid;
  logic [RF_ADDR_W-1:0] wb_rd;
  logic [31:0]          wb_data;

  logic                 flush;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_rs1_data;
  logic [31:0]          out_rs2_data;
  logic [31:0]          out_pc;
  logic [31:0]          out_ctrl;
  logic [RF_ADDR_W-1:0] out_rd;
  logic                 out_rd_we;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_rd_we, in_pc, in_ctrl, rf_rs1_data, rf_rs2_data,
           wb_valid, wb_rd, wb_data, flush, out_ready,
    output in_ready, rf_rs1, rf_rs2, out_valid, out_rs1_data, out_rs2_data,
           out_pc, out_ctrl, out_rd, out_rd_we
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
           in_rd_we, in_pc, in_ctrl, rf_rs1_data, rf_rs2_data,
           wb_valid, wb_rd, wb_data, flush, out_ready,
    input  in_ready, rf_rs1, rf_rs2, out_valid, out_rs1_data, out_rs2_data,
           out_pc, out_ctrl, out_rd, out_rd_we
  );
endinterface

// File: rtl/operand_fetch.sv
// Issue/operand-fetch stage with a pending-write scoreboard that stalls RAW/WAW hazards.
// Optional writeback forwarding is enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch #(
  parameter int unsigned RF_ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_fetch_if.slave    bus
);
  localparam int unsigned NUM_REGS = 1 << RF_ADDR_W;
  localparam int unsigned XLEN     = 32;

  logic [NUM_REGS-1:0]  busy;
  logic [NUM_REGS-1:0]  busy_nxt;
  logic                 out_valid_q;
  logic [XLEN-1:0]      out_rs1_q;
  logic [XLEN-1:0]      out_rs2_q;
  logic [XLEN-1:0]      out_pc_q;
  logic [XLEN-1:0]      out_ctrl_q;
  logic [RF_ADDR_W-1:0] out_rd_q;
  logic                 out_rd_we_q;

  logic                 hz_rs1;
  logic                 hz_rs2;
  logic                 hz_rd;
  logic                 hazard;
  logic                 ready;
  logic                 accept;
  logic [XLEN-1:0]      rs1_data;
  logic [XLEN-1:0]      rs2_data;

`ifdef OPFETCH_BYPASS_EN
  logic wb_hit_rs1;
  logic wb_hit_rs2;
  logic wb_hit_rd;

  assign wb_hit_rs1 = bus.wb_valid && (bus.wb_rd == bus.in_rs1);
  assign wb_hit_rs2 = bus.wb_valid && (bus.wb_rd == bus.in_rs2);
  assign wb_hit_rd  = bus.wb_valid && (bus.wb_rd == bus.in_rd);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^bus.wb_data;
`endif

  // Hazard detection; a register retiring this cycle is not a hazard when forwarding.
  always_comb begin
    hz_rs1 = (bus.in_rs1 != '0) && busy[bus.in_rs1];
    hz_rs2 = (bus.in_rs2 != '0) && busy[bus.in_rs2];
    hz_rd  = (bus.in_rd  != '0) && busy[bus.in_rd];
`ifdef OPFETCH_BYPASS_EN
    hz_rs1 = hz_rs1 && !wb_hit_rs1;
    hz_rs2 = hz_rs2 && !wb_hit_rs2;
    hz_rd  = hz_rd  && !wb_hit_rd;
`endif
    hazard = (bus.in_uses_rs1 && hz_rs1) || (bus.in_uses_rs2 && hz_rs2) ||
             (bus.in_rd_we && hz_rd);
  end

  assign ready  = rst_n && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && ready;

  // Operand select: forward writeback data onto a matching nonzero source.
  always_comb begin
    rs1_data = bus.rf_rs1_data;
    rs2_data = bus.rf_rs2_data;
`ifdef OPFETCH_BYPASS_EN
    if (bus.in_uses_rs1 && (bus.in_rs1 != '0) && wb_hit_rs1) rs1_data = bus.wb_data;
    if (bus.in_uses_rs2 && (bus.in_rs2 != '0) && wb_hit_rs2) rs2_data = bus.wb_data;
`endif
  end

  // Scoreboard update; the set is applied last so a younger writer wins over a retire.
  always_comb begin
    busy_nxt = busy;
    if (bus.wb_valid && (bus.wb_rd != '0)) busy_nxt[bus.wb_rd] = 1'b0;
    if (accept && bus.in_rd_we && (bus.in_rd != '0)) busy_nxt[bus.in_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= '0;
      out_valid_q <= 1'b0;
      out_rs1_q   <= '0;
      out_rs2_q   <= '0;
      out_pc_q    <= '0;
      out_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_rd_we_q <= 1'b0;
    end else if (bus.flush) begin
      busy        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_rs1_q   <= rs1_data;
        out_rs2_q   <= rs2_data;
        out_pc_q    <= bus.in_pc;
        out_ctrl_q  <= bus.in_ctrl;
        out_rd_q    <= bus.in_rd;
        out_rd_we_q <= bus.in_rd_we;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = ready;
  assign bus.rf_rs1       = bus.in_rs1;
  assign bus.rf_rs2       = bus.in_rs2;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_rs1_data = out_rs1_q;
  assign bus.out_rs2_data = out_rs2_q;
  assign bus.out_pc       = out_pc_q;
  assign bus.out_ctrl     = out_ctrl_q;
  assign bus.out_rd       = out_rd_q;
  assign bus.out_rd_we    = out_rd_we_q;
endmodule
